hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core, sitting directly downstream of the ID-stage operand/timing decoder. It consumes per-instruction read addresses, write address, Tuse and Tnew from ID, and keeps its own shadow pipeline of in-flight writers across E, M and W. From that state it raises the D-stage stall and produces forwarding-mux selects for the D, E and M operand paths. It also counts stall cycles for performance debug.

## Interface
- CNT_W, 32, width of the stall-cycle counter (saturating).
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- RA1_ID  in  5  rs read address of the instruction in D; 0 means unused.
- RA2_ID  in  5  rt read address in D; 0 means unused.
- WA_ID  in  5  destination register in D; 0 means no GRF write.
- Tuse_RA1  in  2  cycles (from D) until RA1 value is consumed.
- Tuse_RA2  in  2  cycles (from D) until RA2 value is consumed.
- Tnew  in  2  cycles (from entry into E) until the result exists.
- stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX.
- fwd_D1, fwd_D2  out  2  D operand select: 0 GRF, 1 E, 2 M, 3 W.
- fwd_E1, fwd_E2  out  2  E operand select: 0 ID/EX reg, 2 M, 3 W.
- fwd_M2  out  2  M store-data select: 0 EX/MEM reg, 3 W.
- stall_cnt  out  CNT_W  number of stall cycles since reset.

## Operation
- Shadow stage records: E {WA_E, Tnew_E, RA1_E, RA2_E}, M {WA_M, Tnew_M, RA2_M}, W {WA_W}.
- Advance each edge: if stall=0, E <= {WA_ID, Tnew, RA1_ID, RA2_ID}; if stall=1, E <= all-zero bubble.
- M <= {WA_E, sat_dec(Tnew_E), RA2_E}; W <= WA_M, regardless of stall. sat_dec(x) = x-1 if x>0, else 0.
- Stall (combinational), per operand i in {1,2} with RAi = RAi_ID ≠ 0:
  - (RAi == WA_E and Tnew_E > Tuse_RAi), or
  - (RAi == WA_M and Tnew_M > Tuse_RAi).
- stall = OR over both operands. Register 0 never matches, because WA=0 and RA=0 are excluded.
- D forwarding priority is nearest producer first:
  - E if WA_E==RA and Tnew_E==0;
  - else M if WA_M==RA and Tnew_M==0;
  - else W if WA_W==RA;
  - else 0.
  - A match at E with Tnew_E≠0 blocks fallthrough to M and W; stall covers that case.
- E forwarding: M if WA_M==RAi_E≠0 and Tnew_M==0; else W if WA_W==RAi_E≠0; else 0.
- M forwarding: W if WA_W==RA2_M≠0; else 0.
- stall_cnt increments on every edge where stall=1 and saturates at all-ones.

## Timing
- Reset (rst_n=0, async): all shadow registers and stall_cnt clear to 0.
  - stall=0 and all fwd_*=0 for the whole reset period.
- stall and fwd_* are purely combinational from inputs and registered state; 0-cycle latency.
  - Valid within the same cycle the ID fields are presented.
- One bubble is inserted per stall cycle.
  - Load-use, Tuse 1: 1 stall cycle.
  - Load-beq, Tuse 0: 2 stall cycles.
  - ALU-beq, Tuse 0: 1 stall cycle.
- While stall=1, fwd_D* are don't-care; the E, M and W selects remain valid.
- Reset deasserted mid-stream: pipeline restarts empty; no stale matches.

## Structure
- Shared package: fwd select encodings (FWD_NONE=0, FWD_E=1, FWD_M=2, FWD_W=3), Tnew/Tuse width, register-0 constant.
- One sub-module is natural: fwd_sel. It takes an address, up to three {WA, ready} candidates and an enable mask, and returns a 2-bit select. It is instantiated five times.
- Everything else lives in hazard_ctrl: stage registers, stall logic, counter.

## Test plan
- Reset: hold rst_n=0 with RA1_ID=WA_ID=5 → stall=0, all fwd=0, stall_cnt=0; release, outputs remain 0.
- Load-use: issue lw $8 (WA=8, Tnew=2), then add using RA1=8 (Tuse 1) → stall=1 for exactly 1 cycle; afterwards fwd_E1=3 (W) at E; stall_cnt=1.
- Load-beq: lw $9, then beq RA1=9 (Tuse 0) → 2 stall cycles, then fwd_D1=3; stall_cnt=2.
- ALU chain: addu $3 (Tnew 1), then subu RA2=3 (Tuse 1) → no stall; fwd_E2=2 (M) next cycle.
- jal/$31: jal (WA=31, Tnew 0), then jr RA1=31 (Tuse 0) → no stall, fwd_D1=1 (E).
- $0 and priority: writers to $0 never forward or stall. With both E and M writing $4 and Tnew_E=0 → fwd_D1=1 (E wins). Store RA2=7 in M with W writing $7 → fwd_M2=3.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned T_W   = 2;
  localparam int unsigned REG_W = 5;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_E    = 2'd1,
    FWD_M    = 2'd2,
    FWD_W    = 2'd3
  } fwd_e;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    return (x != '0) ? x - 2'd1 : '0;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one operand: candidate 0 is E, 1 is M, 2 is W (nearest first).
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] addr,
  input  logic [REG_W-1:0] wa0,
  input  logic             rdy0,
  input  logic [REG_W-1:0] wa1,
  input  logic             rdy1,
  input  logic [REG_W-1:0] wa2,
  input  logic             rdy2,
  input  logic [2:0]       en,
  output logic [1:0]       sel
);

  logic hit0, hit1, hit2;

  assign hit0 = en[0] && (wa0 == addr);
  assign hit1 = en[1] && (wa1 == addr) && rdy1;
  assign hit2 = en[2] && (wa2 == addr) && rdy2;

  always_comb begin
    sel = FWD_NONE;
    if (addr != REG_ZERO) begin
      // A not-yet-ready match at E shadows older producers; the stall covers it.
      if (hit0) begin
        sel = rdy0 ? FWD_E : FWD_NONE;
      end else if (hit1) begin
        sel = FWD_M;
      end else if (hit2) begin
        sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadow E/M/W writer pipeline, D-stage stall, forwarding selects,
// and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       RA1_ID,
  input  logic [4:0]       RA2_ID,
  input  logic [4:0]       WA_ID,
  input  logic [1:0]       Tuse_RA1,
  input  logic [1:0]       Tuse_RA2,
  input  logic [1:0]       Tnew,
  output logic             stall,
  output logic [1:0]       fwd_D1,
  output logic [1:0]       fwd_D2,
  output logic [1:0]       fwd_E1,
  output logic [1:0]       fwd_E2,
  output logic [1:0]       fwd_M2,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [REG_W-1:0] wa_e_q, ra1_e_q, ra2_e_q, wa_m_q, ra2_m_q, wa_w_q;
  logic [T_W-1:0]   tnew_e_q, tnew_m_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             hz1, hz2;

  always_comb begin
    hz1 = (RA1_ID != REG_ZERO) &&
          (((RA1_ID == wa_e_q) && (tnew_e_q > Tuse_RA1)) ||
           ((RA1_ID == wa_m_q) && (tnew_m_q > Tuse_RA1)));
    hz2 = (RA2_ID != REG_ZERO) &&
          (((RA2_ID == wa_e_q) && (tnew_e_q > Tuse_RA2)) ||
           ((RA2_ID == wa_m_q) && (tnew_m_q > Tuse_RA2)));
  end

  assign stall     = hz1 | hz2;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_e_q      <= '0;
      tnew_e_q    <= '0;
      ra1_e_q     <= '0;
      ra2_e_q     <= '0;
      wa_m_q      <= '0;
      tnew_m_q    <= '0;
      ra2_m_q     <= '0;
      wa_w_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (stall) begin
        wa_e_q   <= '0;
        tnew_e_q <= '0;
        ra1_e_q  <= '0;
        ra2_e_q  <= '0;
      end else begin
        wa_e_q   <= WA_ID;
        tnew_e_q <= Tnew;
        ra1_e_q  <= RA1_ID;
        ra2_e_q  <= RA2_ID;
      end
      wa_m_q   <= wa_e_q;
      tnew_m_q <= sat_dec(tnew_e_q);
      ra2_m_q  <= ra2_e_q;
      wa_w_q   <= wa_m_q;
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  hazard_ctrl_fwd_sel u_fwd_d1 (
    .addr(RA1_ID), .wa0(wa_e_q), .rdy0(tnew_e_q == '0), .wa1(wa_m_q), .rdy1(tnew_m_q == '0),
    .wa2(wa_w_q), .rdy2(1'b1), .en(3'b111), .sel(fwd_D1)
  );

  hazard_ctrl_fwd_sel u_fwd_d2 (
    .addr(RA2_ID), .wa0(wa_e_q), .rdy0(tnew_e_q == '0), .wa1(wa_m_q), .rdy1(tnew_m_q == '0),
    .wa2(wa_w_q), .rdy2(1'b1), .en(3'b111), .sel(fwd_D2)
  );

  hazard_ctrl_fwd_sel u_fwd_e1 (
    .addr(ra1_e_q), .wa0(REG_ZERO), .rdy0(1'b0), .wa1(wa_m_q), .rdy1(tnew_m_q == '0),
    .wa2(wa_w_q), .rdy2(1'b1), .en(3'b110), .sel(fwd_E1)
  );

  hazard_ctrl_fwd_sel u_fwd_e2 (
    .addr(ra2_e_q), .wa0(REG_ZERO), .rdy0(1'b0), .wa1(wa_m_q), .rdy1(tnew_m_q == '0),
    .wa2(wa_w_q), .rdy2(1'b1), .en(3'b110), .sel(fwd_E2)
  );

  hazard_ctrl_fwd_sel u_fwd_m2 (
    .addr(ra2_m_q), .wa0(REG_ZERO), .rdy0(1'b0), .wa1(REG_ZERO), .rdy1(1'b0),
    .wa2(wa_w_q), .rdy2(1'b1), .en(3'b100), .sel(fwd_M2)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic against a
// list-of-in-flight-writers reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa;
  logic [1:0]  tu1, tu2, tn;
  logic        stall;
  logic [1:0]  fwd_d1, fwd_d2, fwd_e1, fwd_e2, fwd_m2;
  logic [31:0] stall_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .RA1_ID(ra1), .RA2_ID(ra2), .WA_ID(wa),
    .Tuse_RA1(tu1), .Tuse_RA2(tu2), .Tnew(tn), .stall(stall),
    .fwd_D1(fwd_d1), .fwd_D2(fwd_d2), .fwd_E1(fwd_e1), .fwd_E2(fwd_e2), .fwd_M2(fwd_m2),
    .stall_cnt(stall_cnt)
  );

  // In-flight writers: index 0 = E, 1 = M, 2 = W.
  typedef struct {
    logic [4:0] wa;
    int         tnew;
    logic [4:0] ra1;
    logic [4:0] ra2;
  } rec_t;

  rec_t        st[3];
  int unsigned m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int s = 0; s < 3; s++) st[s] = '{wa: 5'd0, tnew: 0, ra1: 5'd0, ra2: 5'd0};
    m_cnt = 0;
  endtask

  function automatic logic m_stall();
    logic [4:0] ra[2];
    int         tu[2];
    ra[0] = ra1; ra[1] = ra2; tu[0] = int'(tu1); tu[1] = int'(tu2);
    for (int i = 0; i < 2; i++)
      for (int s = 0; s < 2; s++)
        if (ra[i] != 0 && st[s].wa == ra[i] && st[s].tnew > tu[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_fwd_d(input logic [4:0] ra);
    if (ra == 0) return 2'd0;
    if (st[0].wa == ra) return (st[0].tnew == 0) ? 2'd1 : 2'd0;
    if (st[1].wa == ra && st[1].tnew == 0) return 2'd2;
    if (st[2].wa == ra) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_fwd_late(input logic [4:0] ra, input bit use_m);
    if (ra == 0) return 2'd0;
    if (use_m && st[1].wa == ra && st[1].tnew == 0) return 2'd2;
    if (st[2].wa == ra) return 2'd3;
    return 2'd0;
  endfunction

  task automatic compare_model();
    chk("stall", {31'd0, stall}, {31'd0, m_stall()});
    if (!m_stall()) begin
      chk("fwd_D1", {30'd0, fwd_d1}, {30'd0, m_fwd_d(ra1)});
      chk("fwd_D2", {30'd0, fwd_d2}, {30'd0, m_fwd_d(ra2)});
    end
    chk("fwd_E1", {30'd0, fwd_e1}, {30'd0, m_fwd_late(st[0].ra1, 1'b1)});
    chk("fwd_E2", {30'd0, fwd_e2}, {30'd0, m_fwd_late(st[0].ra2, 1'b1)});
    chk("fwd_M2", {30'd0, fwd_m2}, {30'd0, m_fwd_late(st[1].ra2, 1'b0)});
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  // Present one D-stage instruction and compare mid-cycle.
  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w,
                       input logic [1:0] u1, input logic [1:0] u2, input logic [1:0] t);
    ra1 = r1; ra2 = r2; wa = w; tu1 = u1; tu2 = u2; tn = t;
    #4;
    compare_model();
  endtask

  task automatic tick();
    logic s;
    s = m_stall();
    @(posedge clk);
    st[2].wa = st[1].wa;
    st[1] = '{wa: st[0].wa, tnew: (st[0].tnew > 0) ? st[0].tnew - 1 : 0, ra1: 5'd0,
              ra2: st[0].ra2};
    if (s) st[0] = '{wa: 5'd0, tnew: 0, ra1: 5'd0, ra2: 5'd0};
    else   st[0] = '{wa: wa, tnew: int'(tn), ra1: ra1, ra2: ra2};
    if (s && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drive(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
      tick();
    end
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    ra1 = 5'd5; ra2 = 5'd0; wa = 5'd5; tu1 = 2'd0; tu2 = 2'd0; tn = 2'd0;
    #3;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fwd_D1", {30'd0, fwd_d1}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #3;
    chk("rst_hold_fwd_D1", {30'd0, fwd_d1}, 32'd0);
    ra1 = 5'd0; wa = 5'd0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    nops(2);

    // Load-use: lw $8 then add reading $8 at Tuse 1.
    drive(5'd0, 5'd0, 5'd8, 2'd0, 2'd0, 2'd2); tick();
    drive(5'd8, 5'd0, 5'd10, 2'd1, 2'd1, 2'd1);
    chk("lu_stall0", {31'd0, stall}, 32'd1); tick();
    drive(5'd8, 5'd0, 5'd10, 2'd1, 2'd1, 2'd1);
    chk("lu_stall1", {31'd0, stall}, 32'd0); tick();
    drive(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
    chk("lu_fwd_E1", {30'd0, fwd_e1}, 32'd3);
    chk("lu_cnt", stall_cnt, 32'd1); tick();
    nops(3);

    // Load-beq: two stall cycles, then W forward into D.
    drive(5'd0, 5'd0, 5'd9, 2'd0, 2'd0, 2'd2); tick();
    for (int i = 0; i < 2; i++) begin
      drive(5'd9, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
      chk("lb_stall", {31'd0, stall}, 32'd1); tick();
    end
    drive(5'd9, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
    chk("lb_nostall", {31'd0, stall}, 32'd0);
    chk("lb_fwd_D1", {30'd0, fwd_d1}, 32'd3); tick();
    drive(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
    chk("lb_cnt", stall_cnt, 32'd3); tick();
    nops(3);

    // ALU chain: no stall, M forward at E.
    drive(5'd0, 5'd0, 5'd3, 2'd0, 2'd0, 2'd1); tick();
    drive(5'd0, 5'd3, 5'd5, 2'd1, 2'd1, 2'd1);
    chk("alu_stall", {31'd0, stall}, 32'd0); tick();
    drive(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
    chk("alu_fwd_E2", {30'd0, fwd_e2}, 32'd2); tick();
    nops(3);

    // jal/jr $31: E forward into D.
    drive(5'd0, 5'd0, 5'd31, 2'd0, 2'd0, 2'd0); tick();
    drive(5'd31, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
    chk("jr_stall", {31'd0, stall}, 32'd0);
    chk("jr_fwd_D1", {30'd0, fwd_d1}, 32'd1); tick();
    nops(3);

    // $0 writer never forwards or stalls.
    drive(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd3); tick();
    drive(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
    chk("r0_stall", {31'd0, stall}, 32'd0);
    chk("r0_fwd_D1", {30'd0, fwd_d1}, 32'd0); tick();
    nops(3);

    // E and M both write $4, both ready: E wins.
    drive(5'd0, 5'd0, 5'd4, 2'd0, 2'd0, 2'd1); tick();
    drive(5'd0, 5'd0, 5'd4, 2'd0, 2'd0, 2'd0); tick();
    drive(5'd4, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
    chk("prio_fwd_D1", {30'd0, fwd_d1}, 32'd1); tick();
    nops(3);

    // Store data: producer of $7 reaches W while the store sits in M.
    drive(5'd0, 5'd0, 5'd7, 2'd0, 2'd0, 2'd0); tick();
    drive(5'd0, 5'd7, 5'd0, 2'd0, 2'd2, 2'd0); tick();
    drive(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
    chk("st_fwd_E2", {30'd0, fwd_e2}, 32'd2); tick();
    drive(5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 2'd0);
    chk("st_fwd_M2", {30'd0, fwd_m2}, 32'd3); tick();

    // Random traffic with a mid-stream reset.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        rst_n = 1'b0;
        model_clear();
        ra1 = 5'($urandom_range(7)); ra2 = 5'($urandom_range(7)); wa = 5'($urandom_range(7));
        tn = 2'($urandom_range(3));
        #3;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_fwd_E1", {30'd0, fwd_e1}, 32'd0);
        chk("mid_rst_cnt", stall_cnt, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
      drive(5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
            2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
